// File: rtl/reg_dump_tx.sv
// Debug register readback: fetch one register over a debug read port, snapshot it and send it
// out as 8N1 UART bytes. Define REG_DUMP_HEX_EN for ASCII hex output instead of raw bytes.
module reg_dump_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned REG_ADDR_W   = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [REG_ADDR_W-1:0] reg_idx,
  output logic [REG_ADDR_W-1:0] dbg_raddr,
  input  logic [31:0]           dbg_rdata,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

`ifdef REG_DUMP_HEX_EN
  localparam int unsigned NBytes = 9;
`else
  localparam int unsigned NBytes = 4;
`endif
  localparam int unsigned    BaudW    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BaudW-1:0] BaudMax = BaudW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]     LastByte = 4'(NBytes - 1);

  typedef enum logic [2:0] {
    StIdle, StFetch, StCapture, StStart, StData, StStop, StFinish
  } state_e;

  state_e           state_q;
  logic [BaudW-1:0] baud_q;
  logic [2:0]       bit_q;
  logic [3:0]       byte_q;
  logic [31:0]      shadow_q;

  logic [7:0] cur_byte;
  logic [2:0] bit_nxt;
  logic       baud_wrap;

  assign bit_nxt   = bit_q + 3'd1;
  assign baud_wrap = (baud_q == BaudMax);

`ifdef REG_DUMP_HEX_EN
  logic [3:0] nibble;

  // Character byte_q: nibbles MSB first, then a trailing newline.
  always_comb begin
    nibble = 4'h0;
    case (byte_q)
      4'd0:    nibble = shadow_q[31:28];
      4'd1:    nibble = shadow_q[27:24];
      4'd2:    nibble = shadow_q[23:20];
      4'd3:    nibble = shadow_q[19:16];
      4'd4:    nibble = shadow_q[15:12];
      4'd5:    nibble = shadow_q[11:8];
      4'd6:    nibble = shadow_q[7:4];
      4'd7:    nibble = shadow_q[3:0];
      default: nibble = 4'h0;
    endcase
    if (byte_q == LastByte) begin
      cur_byte = 8'h0A;
    end else if (nibble < 4'd10) begin
      cur_byte = 8'h30 + {4'h0, nibble};
    end else begin
      cur_byte = 8'h37 + {4'h0, nibble};
    end
  end
`else
  always_comb begin
    cur_byte = 8'h00;
    unique case (byte_q[1:0])
      2'd0: cur_byte = shadow_q[31:24];
      2'd1: cur_byte = shadow_q[23:16];
      2'd2: cur_byte = shadow_q[15:8];
      2'd3: cur_byte = shadow_q[7:0];
    endcase
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      baud_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      shadow_q  <= '0;
      dbg_raddr <= '0;
      tx        <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (state_q inside {StStart, StData, StStop}) begin
        baud_q <= baud_wrap ? '0 : baud_q + BaudW'(1);
      end
      unique case (state_q)
        StIdle: begin
          if (start) begin
            dbg_raddr <= reg_idx;
            busy      <= 1'b1;
            state_q   <= StFetch;
          end
        end
        StFetch: state_q <= StCapture;
        StCapture: begin
          // tx drops on this edge so the frame fills the rest of the busy window exactly.
          shadow_q <= dbg_rdata;
          tx       <= 1'b0;
          baud_q   <= '0;
          bit_q    <= '0;
          byte_q   <= '0;
          state_q  <= StStart;
        end
        StStart: begin
          if (baud_wrap) begin
            tx      <= cur_byte[0];
            state_q <= StData;
          end
        end
        StData: begin
          if (baud_wrap) begin
            bit_q <= bit_nxt;
            if (bit_q == 3'd7) begin
              tx      <= 1'b1;
              state_q <= StStop;
            end else begin
              tx <= cur_byte[bit_nxt];
            end
          end
        end
        StStop: begin
          if (baud_wrap) begin
            if (byte_q == LastByte) begin
              done    <= 1'b1;
              busy    <= 1'b0;
              state_q <= StFinish;
            end else begin
              byte_q  <= byte_q + 4'd1;
              tx      <= 1'b0;
              state_q <= StStart;
            end
          end
        end
        StFinish: state_q <= StIdle;
        default:  state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_dump_tx.sv
// Scoreboard bench for reg_dump_tx: a UART decoder pops expected bytes pushed at each request.
module tb_reg_dump_tx;
  localparam int unsigned C = 4;
`ifdef REG_DUMP_HEX_EN
  localparam int NB = 9;
`else
  localparam int NB = 4;
`endif
  localparam int BusyCyc = 2 + 10 * C * NB;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  reg_idx = 5'd0;
  logic [4:0]  dbg_raddr;
  logic [31:0] dbg_rdata;
  logic        tx, busy, done;

  logic [31:0] regs [32];
  logic [7:0]  exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;

  reg_dump_tx #(.CLKS_PER_BIT(C), .REG_ADDR_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .reg_idx   (reg_idx),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata),
    .tx        (tx),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Register file debug port: one-cycle read latency, x0 hardwired to zero.
  always @(posedge clk) dbg_rdata <= (dbg_raddr == 5'd0) ? 32'h0 : regs[dbg_raddr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input logic [31:0] v);
    int n;
`ifdef REG_DUMP_HEX_EN
    for (int i = 0; i < 8; i++) begin
      n = int'((v >> (28 - 4 * i)) & 32'hF);
      exp_q.push_back(n < 10 ? 8'(48 + n) : 8'(55 + n));
    end
    exp_q.push_back(8'h0A);
`else
    for (int i = 0; i < 4; i++) begin
      n = int'((v >> (24 - 8 * i)) & 32'hFF);
      exp_q.push_back(8'(n));
    end
`endif
  endfunction

  // Called at a falling edge; returns just after the falling edge following acceptance.
  task automatic issue_start(input logic [4:0] idx);
    #1;
    start   = 1'b1;
    reg_idx = idx;
    @(negedge clk);
    check("raddr_latch", dbg_raddr, idx);
    check("busy_set", busy, 1);
    push_frame(idx == 5'd0 ? 32'h0 : regs[idx]);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int elapsed, input bit coincide, input logic [4:0] cur);
    int cnt;
    cnt = elapsed;
    do begin
      @(negedge clk);
      cnt++;
    end while (!done && cnt < BusyCyc + 20);
    check("done_latency", cnt, BusyCyc);
    check("busy_at_done", busy, 0);
    #1;
    if (coincide) begin
      start   = 1'b1;
      reg_idx = ~cur;
    end
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("busy_after_done", busy, 0);
    check("raddr_hold", dbg_raddr, cur);
    #1 start = 1'b0;
  endtask

  // UART 8N1 receiver; a reset seen mid-byte discards that byte.
  initial begin : uart_mon
    logic [7:0] b;
    logic       stop_bit;
    bit         aborted;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        aborted = 1'b0;
        repeat (C / 2) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        for (int i = 0; i < 8; i++) begin
          repeat (C) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          b[i] = tx;
        end
        repeat (C) begin
          @(negedge clk);
          if (rst) aborted = 1'b1;
        end
        stop_bit = tx;
        if (!aborted) begin
          check("stop_bit", stop_bit, 1);
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_byte: got %02h, none expected", b);
          end else begin
            check("rx_byte", b, exp_q.pop_front());
          end
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [4:0] idx;
    for (int i = 0; i < 32; i++) regs[i] = $urandom();

    repeat (3) begin
      @(negedge clk);
      check("rst_tx", tx, 1);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_raddr", dbg_raddr, 0);
    end
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);

    regs[3] = 32'h0000_000A;
    issue_start(5'd3);
    wait_done(0, 1'b0, 5'd3);

    // Snapshot: register changes after capture must not reach the wire.
    regs[10] = 32'hDEAD_BEEF;
    issue_start(5'd10);
    repeat (10) @(negedge clk);
    regs[10] = 32'h1234_5678;
    wait_done(10, 1'b0, 5'd10);

    // Start while busy is ignored; start coincident with done is ignored.
    regs[5] = $urandom();
    issue_start(5'd5);
    repeat (40) @(negedge clk);
    #1;
    start   = 1'b1;
    reg_idx = 5'd1;
    @(negedge clk);
    check("busy_ignore_raddr", dbg_raddr, 5'd5);
    check("busy_ignore_busy", busy, 1);
    #1 start = 1'b0;
    wait_done(41, 1'b1, 5'd5);

    // Accepted on the first cycle after done.
    regs[9] = 32'h00C0_FFEE;
    issue_start(5'd9);
    wait_done(0, 1'b0, 5'd9);

    // Reset during data bit 3 of the second byte.
    idx = 5'($urandom_range(1, 31));
    issue_start(idx);
    repeat (2 + 10 * C + C * 4 + 1) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    check("midrst_tx", tx, 1);
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_raddr", dbg_raddr, 0);
    exp_q.delete();
    #1 rst = 1'b0;
    repeat (30) @(negedge clk);

    regs[0] = 32'hFFFF_FFFF;
    issue_start(5'd0);
    wait_done(0, 1'b0, 5'd0);

    for (int k = 0; k < 5; k++) begin
      idx       = 5'($urandom_range(0, 31));
      regs[idx] = $urandom();
      issue_start(idx);
      wait_done(0, 1'b0, idx);
    end

    repeat (5) @(negedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
